// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the DMEM port-B arbiter:
// the arbiter state encoding, the byte-enable constants and the restart PC.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HOST   = 2'd2,
    RESUME = 2'd3
  } arb_state_t;

  localparam logic [3:0]  BE_WORD  = 4'hF;
  localparam logic [3:0]  BE_NONE  = 4'h0;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // A host access with no byte enables set is a read.
  function automatic logic is_read(input logic [3:0] we);
    return we == BE_NONE;
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational owner select for BRAM port B.
// When the host owns the port, the core's write enables can never reach the BRAM.
module dmem_port_mux #(
  parameter int ADDR_W = 32
) (
  input  logic              host_sel,
  input  logic              host_gnt,
  input  logic [3:0]        core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din
);
  import dmem_port_arbiter_pkg::*;

  always_comb begin
    bram_we   = core_we;
    bram_addr = core_addr;
    bram_din  = core_wdata;
    if (host_sel) begin
      bram_we   = host_gnt ? host_we : BE_NONE;
      bram_addr = host_addr;
      bram_din  = host_wdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Time-shares DMEM port B between the core LSU and a host loader/debugger.
// The core is halted and drained before the host gets the port, and is resumed afterwards.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int BOOT_HALT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_halt,
  output logic              core_restart,
  input  logic              host_halt_req,
  input  logic              host_restart,
  input  logic              host_req,
  input  logic [3:0]        host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              host_owner,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);
  import dmem_port_arbiter_pkg::*;

  localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES);
  localparam arb_state_t BOOT_STATE  = (BOOT_HALT != 0) ? HOST : RUN;
  localparam logic       BOOT_HALTED = (BOOT_HALT != 0);

  arb_state_t state, state_next;
  logic [3:0] drain_cnt, drain_cnt_next;
  logic       host_exit;

  assign host_owner = (state == HOST);
  assign host_gnt   = host_owner && host_req;
  assign host_exit  = !host_halt_req && !host_req && !host_rvalid;

  // BRAM output is already one cycle behind the granted read, so it is forwarded as-is.
  assign host_rdata = host_rvalid ? bram_dout : 32'h0;

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      RUN: begin
        if (host_halt_req) begin
          if (DRAIN_CYCLES == 0) begin
            state_next = HOST;
          end else begin
            state_next     = DRAIN;
            drain_cnt_next = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        drain_cnt_next = (drain_cnt != 4'd0) ? drain_cnt - 4'd1 : 4'd0;
        if (drain_cnt <= 4'd1) state_next = HOST;
      end
      HOST: begin
        if (host_exit) state_next = RESUME;
      end
      RESUME: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // core_halt follows the state being entered, so it drops the cycle RUN resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT_STATE;
      drain_cnt    <= 4'd0;
      host_rvalid  <= 1'b0;
      core_halt    <= BOOT_HALTED;
      core_restart <= 1'b0;
    end else begin
      state        <= state_next;
      drain_cnt    <= drain_cnt_next;
      host_rvalid  <= host_gnt && is_read(host_we);
      core_halt    <= (state_next != RUN);
      core_restart <= (state == HOST) && (state_next == RESUME) && host_restart;
    end
  end

  dmem_port_mux #(
    .ADDR_W(ADDR_W)
  ) u_mux (
    .host_sel  (host_owner),
    .host_gnt  (host_gnt),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a booting/draining instance with a BRAM model
// and a zero-drain, run-from-reset instance for the fast-handover path.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  core_we;
  logic [31:0] core_addr, core_wdata;
  logic        host_halt_req, host_restart, host_req;
  logic [3:0]  host_we;
  logic [31:0] host_addr, host_wdata;

  logic        core_halt, core_restart, host_gnt, host_rvalid, host_owner;
  logic [31:0] host_rdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din, bram_dout;

  logic        z_halt_req, z_host_req;
  logic        z_core_halt, z_core_restart, z_host_gnt, z_host_rvalid, z_host_owner;
  logic [31:0] z_host_rdata;
  logic [3:0]  z_bram_we;
  logic [31:0] z_bram_addr, z_bram_din, z_bram_dout;

  assign z_bram_dout = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bram_mem [0:255];
  logic [31:0] ref_mem  [0:255];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DRAIN_CYCLES(4), .BOOT_HALT(1)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_halt(core_halt), .core_restart(core_restart),
    .host_halt_req(host_halt_req), .host_restart(host_restart),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_owner(host_owner),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DRAIN_CYCLES(0), .BOOT_HALT(0)) dut_z (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_halt(z_core_halt), .core_restart(z_core_restart),
    .host_halt_req(z_halt_req), .host_restart(host_restart),
    .host_req(z_host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(z_host_gnt), .host_rvalid(z_host_rvalid), .host_rdata(z_host_rdata),
    .host_owner(z_host_owner),
    .bram_we(z_bram_we), .bram_addr(z_bram_addr), .bram_din(z_bram_din), .bram_dout(z_bram_dout)
  );

  // Read-first BRAM with one cycle of read latency, wiped on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bram_mem[i] <= 32'h0;
      bram_dout <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bram_mem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
      bram_dout <= bram_mem[bram_addr[9:2]];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic refClear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic refWrite(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    return ref_mem[addr[9:2]];
  endfunction

  initial begin
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        req, rs, released;
    logic [3:0]  we, cwe;
    logic [31:0] addr;
    int          sel;

    refClear();
    rst = 1'b1;
    core_we = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
    host_halt_req = 1'b1; host_restart = 1'b0;
    z_halt_req = 1'b0; z_host_req = 1'b0;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rst_core_halt", core_halt, 1);
    checkOutput("rst_host_owner", host_owner, 1);
    checkOutput("rst_host_gnt", host_gnt, 0);
    checkOutput("rst_host_rvalid", host_rvalid, 0);
    checkOutput("rst_host_rdata", host_rdata, 0);
    checkOutput("rst_core_restart", core_restart, 0);
    checkOutput("rst_z_core_halt", z_core_halt, 0);
    checkOutput("rst_z_host_owner", z_host_owner, 0);

    // Boot load: host writes the first instruction, then reads it back.
    nextCycle();
    applyStimulus(1'b1, 4'hF, 32'h0, 32'h0000_0013);
    #1;
    checkOutput("boot_wr_gnt", host_gnt, 1);
    checkOutput("boot_wr_bram_we", bram_we, 4'hF);
    checkOutput("boot_wr_bram_addr", bram_addr, 32'h0);
    checkOutput("boot_wr_bram_din", bram_din, 32'h0000_0013);
    refWrite(4'hF, 32'h0, 32'h0000_0013);

    nextCycle();
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("boot_rd_gnt", host_gnt, 1);
    checkOutput("boot_rd_bram_we", bram_we, 4'h0);
    checkOutput("boot_rd_rvalid_early", host_rvalid, 0);

    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("boot_rd_rvalid", host_rvalid, 1);
    checkOutput("boot_rd_rdata", host_rdata, 32'h0000_0013);

    nextCycle();
    host_halt_req = 1'b0;
    #1;
    checkOutput("boot_rvalid_pulse", host_rvalid, 0);
    checkOutput("boot_exit_owner", host_owner, 1);

    nextCycle();
    #1;
    checkOutput("boot_resume_owner", host_owner, 0);
    checkOutput("boot_resume_halt", core_halt, 1);
    checkOutput("boot_resume_restart", core_restart, 0);

    // RUN passthrough with a host request that must be ignored.
    nextCycle();
    core_we = 4'b0011; core_addr = 32'h100; core_wdata = 32'h0000_ABCD;
    applyStimulus(1'b1, 4'hF, 32'h200, 32'hFFFF_FFFF);
    #1;
    checkOutput("run_core_halt", core_halt, 0);
    checkOutput("run_bram_we", bram_we, 4'b0011);
    checkOutput("run_bram_addr", bram_addr, 32'h100);
    checkOutput("run_bram_din", bram_din, 32'h0000_ABCD);
    checkOutput("run_host_gnt", host_gnt, 0);
    refWrite(4'b0011, 32'h100, 32'h0000_ABCD);

    // Halt request: the core keeps storing through four drain cycles.
    nextCycle();
    host_halt_req = 1'b1;
    core_we = 4'hF; core_addr = 32'h110; core_wdata = 32'hD0;
    applyStimulus(1'b1, 4'h0, 32'h120, 32'h0);
    #1;
    checkOutput("halt_req_core_halt", core_halt, 0);
    checkOutput("halt_req_gnt", host_gnt, 0);
    refWrite(4'hF, 32'h110, 32'hD0);

    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      core_addr  = 32'h110 + 32'(4 * k);
      core_wdata = 32'hD0 + 32'(k);
      if (k == 2) host_halt_req = 1'b0;
      if (k == 4) host_halt_req = 1'b1;
      #1;
      checkOutput("drain_core_halt", core_halt, 1);
      checkOutput("drain_owner", host_owner, 0);
      checkOutput("drain_gnt", host_gnt, 0);
      checkOutput("drain_bram_we", bram_we, 4'hF);
      checkOutput("drain_bram_addr", bram_addr, 32'h110 + 32'(4 * k));
      refWrite(4'hF, 32'h110 + 32'(4 * k), 32'hD0 + 32'(k));
    end

    nextCycle();
    core_addr = 32'h200; core_wdata = 32'h0BAD;
    #1;
    checkOutput("host_first_owner", host_owner, 1);
    checkOutput("host_first_gnt", host_gnt, 1);
    checkOutput("host_core_we_blocked", bram_we, 4'h0);
    checkOutput("host_first_addr", bram_addr, 32'h120);
    checkOutput("host_first_halt", core_halt, 1);

    // Release in the same cycle as a read, with restart requested.
    nextCycle();
    core_we = 4'h0;
    host_halt_req = 1'b0; host_restart = 1'b1;
    applyStimulus(1'b1, 4'h0, 32'h100, 32'h0);
    #1;
    checkOutput("rel_gnt", host_gnt, 1);
    checkOutput("rel_drain_commit_rvalid", host_rvalid, 1);
    checkOutput("rel_drain_commit_rdata", host_rdata, refRead(32'h120));

    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("rel_rd_rvalid", host_rvalid, 1);
    checkOutput("rel_rd_rdata", host_rdata, 32'h0000_ABCD);
    checkOutput("rel_rd_owner", host_owner, 1);
    checkOutput("rel_rd_restart", core_restart, 0);

    nextCycle();
    #1;
    checkOutput("rel_idle_rvalid", host_rvalid, 0);
    checkOutput("rel_idle_owner", host_owner, 1);

    nextCycle();
    host_restart = 1'b0;
    #1;
    checkOutput("resume_owner", host_owner, 0);
    checkOutput("resume_restart", core_restart, 1);
    checkOutput("resume_halt", core_halt, 1);

    nextCycle();
    host_halt_req = 1'b1;
    #1;
    checkOutput("run_again_restart", core_restart, 0);
    checkOutput("run_again_halt", core_halt, 0);

    // Reset on the second drain cycle.
    nextCycle();
    #1;
    checkOutput("drain1_halt", core_halt, 1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("drain2_gnt", host_gnt, 0);
    refClear();

    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("mid_rst_core_halt", core_halt, 1);
    checkOutput("mid_rst_owner", host_owner, 1);
    checkOutput("mid_rst_rvalid", host_rvalid, 0);
    checkOutput("mid_rst_rdata", host_rdata, 0);
    checkOutput("mid_rst_gnt", host_gnt, 0);
    checkOutput("mid_rst_restart", core_restart, 0);
    checkOutput("mid_rst_z_halt", z_core_halt, 0);

    nextCycle();
    #1;
    checkOutput("mid_rst_no_stray_rvalid", host_rvalid, 0);

    // Random host traffic against the memory model while the core is blocked out.
    exp_rv = 1'b0;
    exp_rd = 32'h0;
    for (int i = 0; i < 60; i++) begin
      nextCycle();
      req  = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 3));
      we   = (sel < 2) ? 4'h0 : (sel == 2) ? 4'hF : 4'($urandom_range(1, 15));
      addr = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      cwe  = 4'($urandom_range(1, 15));
      core_we = cwe; core_addr = $urandom; core_wdata = $urandom;
      applyStimulus(req, we, addr, $urandom);
      #1;
      checkOutput("rnd_owner", host_owner, 1);
      checkOutput("rnd_gnt", host_gnt, req);
      checkOutput("rnd_bram_we", bram_we, req ? we : 4'h0);
      checkOutput("rnd_rvalid", host_rvalid, exp_rv);
      if (exp_rv) checkOutput("rnd_rdata", host_rdata, exp_rd);
      exp_rv = req && (we == 4'h0);
      if (exp_rv) exp_rd = refRead(addr);
      if (req && we != 4'h0) refWrite(we, addr, host_wdata);
    end

    nextCycle();
    rs = 1'($urandom_range(0, 1));
    core_we = 4'h0;
    host_halt_req = 1'b0; host_restart = rs;
    applyStimulus(1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("rnd_last_rvalid", host_rvalid, exp_rv);
    if (exp_rv) checkOutput("rnd_last_rdata", host_rdata, exp_rd);

    released = 1'b0;
    for (int c = 0; c < 4 && !released; c++) begin
      nextCycle();
      #1;
      if (!host_owner) released = 1'b1;
    end
    checkOutput("rnd_release_seen", released, 1);
    checkOutput("rnd_resume_restart", core_restart, rs);
    checkOutput("rnd_resume_halt", core_halt, 1);
    nextCycle();
    host_restart = 1'b0;
    #1;
    checkOutput("rnd_run_halt", core_halt, 0);
    checkOutput("rnd_run_restart", core_restart, 0);

    // Zero drain: host gets the port one cycle after asking.
    nextCycle();
    core_we = 4'h5; core_addr = 32'h40;
    z_halt_req = 1'b1; z_host_req = 1'b1;
    #1;
    checkOutput("z_req_gnt", z_host_gnt, 0);
    checkOutput("z_req_owner", z_host_owner, 0);
    checkOutput("z_req_halt", z_core_halt, 0);
    checkOutput("z_req_bram_we", z_bram_we, 4'h5);

    nextCycle();
    #1;
    checkOutput("z_host_owner", z_host_owner, 1);
    checkOutput("z_host_gnt", z_host_gnt, 1);
    checkOutput("z_host_halt", z_core_halt, 1);
    checkOutput("z_host_bram_we", z_bram_we, 4'hF);

    nextCycle();
    z_halt_req = 1'b0; z_host_req = 1'b0;
    #1;
    checkOutput("z_exit_owner", z_host_owner, 1);
    nextCycle();
    #1;
    checkOutput("z_resume_owner", z_host_owner, 0);
    checkOutput("z_resume_halt", z_core_halt, 1);
    checkOutput("z_resume_restart", z_core_restart, 0);
    nextCycle();
    #1;
    checkOutput("z_run_halt", z_core_halt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
